// File: rtl/ps2_pkg.sv
// Shared constants and FIFO entry layout for the PS/2 receiver.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;
  localparam logic [7:0]  PS2_BRK_CODE   = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } entry_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronises raw PS/2 clock/data, debounces the clock over FILTER_LEN
// samples and emits a one-cycle strobe with the data bit on each falling edge.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic strobe,
  output logic bit_val
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_sync <= '1;
      dat_sync <= '1;
      filt     <= 1'b1;
      cnt      <= '0;
      strobe   <= 1'b0;
      bit_val  <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      strobe   <= 1'b0;
      // Any sample agreeing with the filtered level restarts the run count.
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        cnt  <= '0;
        if (filt) begin
          strobe  <= 1'b1;
          bit_val <= dat_sync[1];
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with show-ahead FIFO and sticky error flags.
// Define PS2_RX_TAG_EN to fold E0/F0 prefixes into ext/brk tags per entry.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               rdn,
  input  logic               clr_err,
  output logic [7:0]         data,
  output logic               ext,
  output logic               brk,
  output logic               ready,
  output logic [FIFO_AW:0]   level,
  output logic               overflow,
  output logic               parity_err,
  output logic               frame_err
);

  localparam int unsigned       DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]  DEPTH_L = (FIFO_AW + 1)'(DEPTH);
  localparam int unsigned       TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]        LAST    = 4'(PS2_FRAME_BITS - 1);

  logic               strobe, bit_val;
  logic [3:0]         bitcnt;
  logic [9:0]         shreg;
  logic [TW-1:0]      tcnt;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               frame_done, frame_bad, par_bad, frame_ok, timeout;
  logic               push_req, push, pop, ovf_set;
  logic [7:0]         rx_byte;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk     (clk),
    .clr     (clr),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .strobe  (strobe),
    .bit_val (bit_val)
  );

`ifdef PS2_RX_TAG_EN
  entry_t mem [DEPTH];
  entry_t wr_entry;
  logic   ext_pend, brk_pend;
  assign wr_entry = '{code: rx_byte, ext: ext_pend, brk: brk_pend};
  assign data     = mem[rd_ptr].code;
  assign ext      = mem[rd_ptr].ext;
  assign brk      = mem[rd_ptr].brk;
`else
  logic [7:0] mem [DEPTH];
  logic [7:0] wr_entry;
  assign wr_entry = rx_byte;
  assign data     = mem[rd_ptr];
  assign ext      = 1'b0;
  assign brk      = 1'b0;
`endif

  assign ready   = (level != '0);
  assign rx_byte = shreg[8:1];

  always_comb begin
    frame_done = strobe && (bitcnt == LAST);
    frame_bad  = frame_done && (shreg[0] != 1'b0 || bit_val != 1'b1);
    par_bad    = frame_done && !(^shreg[9:1]);
    frame_ok   = frame_done && !frame_bad && !par_bad;
    timeout    = !strobe && (bitcnt != '0) && (tcnt == TW'(TIMEOUT_CYC - 1));
`ifdef PS2_RX_TAG_EN
    push_req   = frame_ok && rx_byte != PS2_EXT_CODE && rx_byte != PS2_BRK_CODE;
`else
    push_req   = frame_ok;
`endif
    pop        = !rdn && ready;
    push       = push_req && (level < DEPTH_L || pop);
    ovf_set    = push_req && !push;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bitcnt     <= '0;
      shreg      <= '0;
      tcnt       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (strobe) begin
        tcnt <= '0;
        if (bitcnt == LAST) begin
          bitcnt <= '0;
        end else begin
          bitcnt <= bitcnt + 1'b1;
          shreg  <= {bit_val, shreg[9:1]};
        end
      end else if (timeout || bitcnt == '0) begin
        tcnt   <= '0;
        bitcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      // A setting event wins over a coincident clr_err.
      overflow   <= (overflow   & ~clr_err) | ovf_set;
      parity_err <= (parity_err & ~clr_err) | par_bad;
      frame_err  <= (frame_err  & ~clr_err) | frame_bad | timeout;
    end
  end

`ifdef PS2_RX_TAG_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (frame_ok) begin
      if (rx_byte == PS2_EXT_CODE) begin
        ext_pend <= 1'b1;
      end else if (rx_byte == PS2_BRK_CODE) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo; exercises the PS2_RX_TAG_EN path when defined.
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rdn = 1'b1;
  logic       clr_err = 1'b0;
  logic [7:0] data;
  logic       ext, brk, ready;
  logic [3:0] level;
  logic       overflow, parity_err, frame_err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  ps2_rx_fifo #(.FIFO_AW(3), .FILTER_LEN(4), .TIMEOUT_CYC(1000)) dut (
    .clk       (clk),
    .clr       (clr),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rdn       (rdn),
    .clr_err   (clr_err),
    .data      (data),
    .ext       (ext),
    .brk       (brk),
    .ready     (ready),
    .level     (level),
    .overflow  (overflow),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Sends nbits of a frame at a 40-cycle bit period. glitch inserts a
  // 2-cycle low pulse during bit 4's high phase; pop_last holds rdn low for
  // exactly the cycle the final bit is evaluated.
  task automatic send_bits(input logic [10:0] bits, input int unsigned nbits,
                           input bit glitch, input bit pop_last);
    for (int unsigned i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch && i == 4) begin
        repeat (8) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      ps2_clk = 1'b0;
      if (pop_last && i == 10) begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        rdn = 1'b0;
        @(negedge clk);
        rdn = 1'b1;
        repeat (12) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0), 11, 1'b0, 1'b0);
  endtask

  task automatic pulse_clr_err();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic read_one(input logic [7:0] exp, input string name);
    @(negedge clk);
    tests++;
    if (data !== exp || ready !== 1'b1) begin
      fails++;
      $display("FAIL %s: data=%h ready=%b, expected data=%h ready=1", name, data, ready, exp);
    end
    rdn = 1'b0;
    @(negedge clk);
    rdn = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (ready !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 ||
        parity_err !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset: ready=%b level=%0d ovf=%b par=%b frm=%b, expected all 0",
               ready, level, overflow, parity_err, frame_err);
    end
    clr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    send_byte(8'h1C);
    tests++;
    if (ready !== 1'b1 || data !== 8'h1C || level !== 4'd1) begin
      fails++;
      $display("FAIL single_rx: ready=%b data=%h level=%0d, expected 1 1c 1", ready, data, level);
    end
    @(negedge clk); rdn = 1'b0;
    @(negedge clk); rdn = 1'b1;
    tests++;
    if (ready !== 1'b0 || level !== 4'd0) begin
      fails++;
      $display("FAIL single_pop: ready=%b level=%0d, expected 0 0", ready, level);
    end
    @(negedge clk); rdn = 1'b0;
    @(negedge clk); rdn = 1'b1;
    tests++;
    if (ready !== 1'b0 || level !== 4'd0) begin
      fails++;
      $display("FAIL empty_pop: ready=%b level=%0d, expected 0 0", ready, level);
    end
  endtask

  task automatic test_parity();
    send_bits(make_frame(8'h1C, 1'b1), 11, 1'b0, 1'b0);
    tests++;
    if (parity_err !== 1'b1 || ready !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL parity_err: par=%b ready=%b frm=%b, expected 1 0 0", parity_err, ready, frame_err);
    end
    pulse_clr_err();
    tests++;
    if (parity_err !== 1'b0) begin
      fails++;
      $display("FAIL parity_clear: par=%b, expected 0", parity_err);
    end
  endtask

  task automatic test_overflow();
    for (int unsigned i = 1; i <= 9; i++) send_byte(8'(i));
    tests++;
    if (level !== 4'd8 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_fill: level=%0d ovf=%b, expected 8 1", level, overflow);
    end
    for (int unsigned i = 1; i <= 8; i++) read_one(8'(i), "overflow_order");
    tests++;
    if (overflow !== 1'b1 || ready !== 1'b0) begin
      fails++;
      $display("FAIL overflow_sticky: ovf=%b ready=%b, expected 1 0", overflow, ready);
    end
    pulse_clr_err();
  endtask

  task automatic test_timeout_glitch();
    send_bits(make_frame(8'h33, 1'b0), 5, 1'b0, 1'b0);
    repeat (1010) @(negedge clk);
    tests++;
    if (frame_err !== 1'b1 || ready !== 1'b0) begin
      fails++;
      $display("FAIL timeout: frm=%b ready=%b, expected 1 0", frame_err, ready);
    end
    pulse_clr_err();
    send_byte(8'h29);
    send_bits(make_frame(8'h29, 1'b0), 11, 1'b1, 1'b0);
    tests++;
    if (level !== 4'd2 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
      fails++;
      $display("FAIL glitch_frames: level=%0d frm=%b par=%b, expected 2 0 0", level, frame_err, parity_err);
    end
    read_one(8'h29, "after_timeout");
    read_one(8'h29, "glitch_frame");
  endtask

  task automatic test_reset_pushpop();
    send_byte(8'h44);
    send_bits(make_frame(8'h77, 1'b0), 5, 1'b0, 1'b0);
    @(negedge clk); clr = 1'b1;
    repeat (3) @(negedge clk); clr = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h5A);
    tests++;
    if (level !== 4'd1 || data !== 8'h5A || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_midframe: level=%0d data=%h frm=%b, expected 1 5a 0", level, data, frame_err);
    end
    for (int unsigned i = 1; i <= 7; i++) send_byte(8'(8'h10 + i));
    tests++;
    if (level !== 4'd8) begin
      fails++;
      $display("FAIL full_level: level=%0d, expected 8", level);
    end
    send_bits(make_frame(8'h18, 1'b0), 11, 1'b0, 1'b1);
    tests++;
    if (level !== 4'd8 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL push_pop_full: level=%0d ovf=%b, expected 8 0", level, overflow);
    end
    for (int unsigned i = 1; i <= 8; i++) read_one(8'(8'h10 + i), "push_pop_order");
  endtask

`ifdef PS2_RX_TAG_EN
  task automatic test_tags();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    tests++;
    if (level !== 4'd1 || data !== 8'h75 || ext !== 1'b1 || brk !== 1'b1) begin
      fails++;
      $display("FAIL tag_prefix: level=%0d data=%h ext=%b brk=%b, expected 1 75 1 1", level, data, ext, brk);
    end
    @(negedge clk); rdn = 1'b0;
    @(negedge clk); rdn = 1'b1;
    send_byte(8'h1C);
    tests++;
    if (level !== 4'd1 || data !== 8'h1C || ext !== 1'b0 || brk !== 1'b0) begin
      fails++;
      $display("FAIL tag_cleared: level=%0d data=%h ext=%b brk=%b, expected 1 1c 0 0", level, data, ext, brk);
    end
  endtask
`else
  task automatic test_tags();
    send_byte(8'hE0);
    tests++;
    if (level !== 4'd1 || data !== 8'hE0 || ext !== 1'b0 || brk !== 1'b0) begin
      fails++;
      $display("FAIL untagged_prefix: level=%0d data=%h ext=%b brk=%b, expected 1 e0 0 0", level, data, ext, brk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_overflow();
    test_timeout_glitch();
    test_reset_pushpop();
    test_tags();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver with a configurable-depth show-ahead FIFO, successor to the fixed 8-entry keyboard port. Adds ps2_clk glitch filtering, a partial-frame timeout, separate sticky parity/framing/overflow flags, full-depth FIFO use and a fill-level output. Sits on the MIO bus and is read by the CPU with an active-low read strobe.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries, all usable
FILTER_LEN, 4, consecutive equal synchronised samples required before filtered ps2_clk changes (>=1)
TIMEOUT_CYC, 100000, clk cycles without a bit strobe after which a partial frame is discarded (2 ms at 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
clr  in  1  reset, asynchronous, active-high
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
rdn  in  1  read strobe, active low; pops one entry per cycle held low while ready
clr_err  in  1  single-cycle pulse, clears sticky error flags
data  out  8  head-of-FIFO byte (show-ahead, combinational from storage)
ext  out  1  head entry preceded by E0 prefix (feature only, else 0)
brk  out  1  head entry preceded by F0 prefix (feature only, else 0)
ready  out  1  FIFO not empty
level  out  FIFO_AW+1  number of stored entries
overflow  out  1  sticky: valid frame dropped because FIFO full
parity_err  out  1  sticky: frame with even parity discarded
frame_err  out  1  sticky: bad start/stop bit or timeout

Behaviour:
- Reset (clr high, async): pointers, level, bit counter, timeout counter, filter state, prefix tags, all flags = 0; filtered clock = 1; ready=0. FIFO storage not reset. Frame in progress at reset is lost.
- ps2_clk and ps2_data each pass a 2-FF synchroniser. Filtered clock changes only after FILTER_LEN consecutive synced samples differ from its current value; shorter pulses ignored.
- Bit strobe: one-cycle pulse on filtered clock 1->0; samples synced ps2_data.
- Frame: 11 bits: start(0), d0..d7 LSB first, odd parity, stop(1). Bit counter 0..10; on 11th strobe evaluate and return counter to 0.
- Evaluation: start!=0 or stop!=1 -> frame_err=1, no push. Parity (XOR d0..d7,p) == 0 -> parity_err=1, no push. Both errors: set both.
- Valid frame: push when level<DEPTH or a pop occurs the same cycle; otherwise drop, overflow=1. Push visible on data/ready the cycle after the 11th strobe.
- Timeout: counter runs while bit counter != 0, clears on every strobe; reaching TIMEOUT_CYC -> bit counter=0, frame_err=1.
- Pop: cycle with rdn=0 and ready=1 advances read pointer, level-1. rdn=0 while empty ignored. Simultaneous push+pop: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; full/empty decided by level, not pointer comparison.
- Flags sticky until clr_err or reset; reads do not clear overflow. Event setting a flag in same cycle as clr_err: flag ends 1.

Optional Feature:
PS2_RX_TAG_EN: defined -> FIFO entries 10 bits; valid byte E0 sets pending ext, F0 sets pending brk, neither pushed; next other valid byte pushed with tags, then tags cleared (also cleared if that byte is dropped on overflow). Errors do not clear tags. Undefined -> every valid byte pushed, ext=brk=0, entries 8 bits.

Decomposition:
- Package ps2_pkg: PS2_FRAME_BITS=11, PS2_EXT_CODE=8'hE0, PS2_BRK_CODE=8'hF0, entry struct typedef (code, ext, brk).
- Sub-module ps2_sync_filter: synchroniser + FILTER_LEN filter + falling-edge strobe; instantiated once.

Test Plan:
- FILTER_LEN=4, 40-cycle bit period, frame 0x1C odd parity -> ready=1, data=0x1C, level=1; rdn low 1 cycle -> ready=0, level=0.
- Frame 0x1C with parity bit 0 -> parity_err=1, ready=0; clr_err pulse -> parity_err=0.
- FIFO_AW=3, 9 frames 0x01..0x09 with no reads -> level=8, overflow=1; 8 reads return 0x01..0x08 in order; overflow stays 1.
- 5 bits then idle TIMEOUT_CYC+10 cycles -> frame_err=1; next full frame 0x29 -> data=0x29; 2-cycle low glitch on ps2_clk mid-frame -> no extra bit, frame 0x29 still correct.
- Reset asserted mid-frame then released, then frame 0x5A -> only 0x5A stored, level=1; push and pop same cycle at level=8 -> level stays 8, overflow stays 0.
- PS2_RX_TAG_EN: frames E0,F0,75 -> single entry data=0x75, ext=1, brk=1; following 1C -> data=0x1C, ext=0, brk=0.
